// File: rtl/risc_pkg.sv
// Shared opcodes, FSM state type and default widths for the execute stage.
// Latency: n/a (package only).
// Backpressure: n/a.
package risc_pkg;

    localparam int unsigned RISC_DATA_W      = 8;
    localparam int unsigned RISC_TIMEOUT_CYC = 15;
    localparam int unsigned RF_DEPTH         = 8;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_LD  = 4'b1110;
    localparam logic [3:0] OP_ST  = 4'b1111;

    typedef enum logic {
        ST_EXEC = 1'b0,
        ST_MEM  = 1'b1
    } eu_state_e;

    // Opcodes 1001..1101 fall outside this range and execute as nop.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU: add/sub/logic/shift with carry, borrow or shifted-out bit.
// Latency: 0 cycles.
// Backpressure: none (pure function of inputs).
module risc_alu
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W = RISC_DATA_W
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/risc_execute.sv
// Execute/writeback stage: 8-entry register file, ALU ops and ld/st via req/ack; RISC_EU_TIMEOUT_EN adds a memory-wait timeout.
// Latency: ALU result on wb_* one cycle after issue; ld/st occupy >= 2 cycles.
// Backpressure: eu_stall holds the front end while a memory access is outstanding.
module risc_execute
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W      = RISC_DATA_W,
    parameter int unsigned TIMEOUT_CYC = RISC_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        du_opcode,
    input  logic [3:0]        dmaddr,
    input  logic [2:0]        opnda,
    input  logic [2:0]        opndb,
    input  logic [2:0]        dst,
    output logic              eu_stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [3:0]        dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              wb_valid,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              eu_err
);

    eu_state_e         state_q;
    eu_state_e         state_d;
    logic [DATA_W-1:0] rf [RF_DEPTH];
    logic [2:0]        ld_dst_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              is_alu;
    logic              is_ld;
    logic              is_st;
    logic              timeout;

    assign is_alu   = is_alu_op(du_opcode);
    assign is_ld    = (du_opcode == OP_LD);
    assign is_st    = (du_opcode == OP_ST);
    assign eu_stall = (state_q == ST_MEM);

    risc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (du_opcode),
        .a      (rf[opnda]),
        .b      (rf[opndb]),
        .result (alu_res),
        .carry  (alu_c)
    );

`ifdef RISC_EU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             eu_err_q;

    // Fires on the TIMEOUT_CYC-th MEM cycle without ack; a same-cycle ack wins.
    assign timeout = (state_q == ST_MEM) && !dm_ack &&
                     (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign eu_err  = eu_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            eu_err_q <= 1'b0;
        end else begin
            if (state_q == ST_EXEC) begin
                to_cnt_q <= '0;
            end else if (!dm_ack) begin
                to_cnt_q <= to_cnt_q + CNT_W'(1);
            end
            if (timeout) begin
                eu_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign eu_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EXEC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EXEC: begin
                if (is_ld || is_st) begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                if (dm_ack || timeout) begin
                    state_d = ST_EXEC;
                end
            end
            default: state_d = ST_EXEC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RF_DEPTH); i++) begin
                rf[i] <= '0;
            end
            ld_dst_q <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state_q)
                ST_EXEC: begin
                    if (is_alu) begin
                        rf[dst]  <= alu_res;
                        wb_valid <= 1'b1;
                        wb_addr  <= dst;
                        wb_data  <= alu_res;
                        flag_z   <= (alu_res == '0);
                        flag_c   <= alu_c;
                    end else if (is_ld) begin
                        dm_req   <= 1'b1;
                        dm_we    <= 1'b0;
                        dm_addr  <= dmaddr;
                        ld_dst_q <= dst;
                    end else if (is_st) begin
                        dm_req   <= 1'b1;
                        dm_we    <= 1'b1;
                        dm_addr  <= dmaddr;
                        dm_wdata <= rf[opnda];
                    end
                end
                ST_MEM: begin
                    // Request fields stay frozen here; decode inputs are don't-care.
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (!dm_we) begin
                            rf[ld_dst_q] <= dm_rdata;
                            wb_valid     <= 1'b1;
                            wb_addr      <= ld_dst_q;
                            wb_data      <= dm_rdata;
                        end
                    end else if (timeout) begin
                        dm_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
